// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: register address width,
// FSM state encoding and the bundled stall/flush control word.
package pipeline_hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_exe;
    logic stall_mem;
    logic flush_id;
    logic flush_exe;
  } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_unit_compare.sv
// hazard_compare: purely combinational load-use detector. Flags when the
// instruction in EXE is a register-writing load whose destination (non-zero)
// is read by the instruction in ID.
import pipeline_hazard_unit_pkg::*;

module hazard_compare (
  input  reg_addr_t i_rs1_id,
  input  reg_addr_t i_rs2_id,
  input  logic      i_use_rs1,
  input  logic      i_use_rs2,
  input  reg_addr_t i_rd_exe,
  input  logic      i_we_exe,
  input  logic      i_load_exe,
  output logic      loadUse
);

  logic w_is_load;
  logic w_hit1;
  logic w_hit2;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_is_load = i_we_exe & i_load_exe & (i_rd_exe != '0);
  assign w_hit1    = i_use_rs1 & (i_rs1_id == i_rd_exe);
  assign w_hit2    = i_use_rs2 & (i_rs2_id == i_rd_exe);
  assign loadUse   = w_is_load & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush controller for a 5-stage pipeline.
// Priority: memory stall > redirect (branch or pending) > load-use bubble.
// Outputs are Mealy (state + current inputs) and forced to 0 during reset.
// Optional macro HAZARD_PERF_EN adds saturating stallCycles/bubbleCount.
import pipeline_hazard_unit_pkg::*;

module pipeline_hazard_unit (
  input  logic       clk,
  input  logic       rst,
  input  reg_addr_t  rs1_id,
  input  reg_addr_t  rs2_id,
  input  logic       useRs1_id,
  input  logic       useRs2_id,
  input  reg_addr_t  rd_exe,
  input  logic       registerWriteEnable_exe,
  input  logic       regSelect_exe,
  input  logic       branchTaken_exe,
  input  logic       memReq_mem,
  input  logic       dmemReady,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_exe,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_exe,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stallCycles,
  output logic [31:0] bubbleCount,
`endif
  output logic [1:0] hazardState
);

  hz_state_e r_state;
  logic      r_pend;

  hz_state_e w_next;
  logic      w_pend_next;
  hz_ctrl_t  w_ctrl;
  hz_ctrl_t  w_out;
  logic      w_mem_stall;
  logic      w_load_use;

  hazard_compare u_cmp (
    .i_rs1_id   (rs1_id),
    .i_rs2_id   (rs2_id),
    .i_use_rs1  (useRs1_id),
    .i_use_rs2  (useRs2_id),
    .i_rd_exe   (rd_exe),
    .i_we_exe   (registerWriteEnable_exe),
    .i_load_exe (regSelect_exe),
    .loadUse    (w_load_use)
  );

  assign w_mem_stall = memReq_mem & ~dmemReady;

  // Next-state and Mealy control decode
  always_comb begin
    w_ctrl      = '0;
    w_next      = ST_RUN;
    w_pend_next = r_pend;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          w_ctrl.stall_if  = 1'b1;
          w_ctrl.stall_id  = 1'b1;
          w_ctrl.stall_exe = 1'b1;
          w_ctrl.stall_mem = 1'b1;
          w_next           = ST_MEM_WAIT;
          // A branch that cannot redirect now is remembered for release
          if (branchTaken_exe) w_pend_next = 1'b1;
        end else if (branchTaken_exe | r_pend) begin
          w_ctrl.flush_id  = 1'b1;
          w_ctrl.flush_exe = 1'b1;
          w_next           = ST_REDIRECT;
          w_pend_next      = 1'b0;
        end else if (w_load_use) begin
          // Hold PC and IF/ID, inject one bubble into ID/EXE
          w_ctrl.stall_if  = 1'b1;
          w_ctrl.stall_id  = 1'b1;
          w_ctrl.flush_exe = 1'b1;
          w_next           = ST_RUN;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        // EXE holds a bubble here: branch and load-use inputs are ignored
        if (w_mem_stall) begin
          w_ctrl.stall_if  = 1'b1;
          w_ctrl.stall_id  = 1'b1;
          w_ctrl.stall_exe = 1'b1;
          w_ctrl.stall_mem = 1'b1;
          w_next           = ST_REDIRECT;
        end else begin
          w_ctrl.flush_id = 1'b1;
          w_next          = ST_RUN;
          w_pend_next     = 1'b0;
        end
      end
      default: begin
        w_next      = ST_RUN;
        w_pend_next = 1'b0;
      end
    endcase
  end

  // Reset overrides every control output, whatever the inputs are doing
  assign w_out       = rst ? w_ctrl : '0;
  assign stall_if    = w_out.stall_if;
  assign stall_id    = w_out.stall_id;
  assign stall_exe   = w_out.stall_exe;
  assign stall_mem   = w_out.stall_mem;
  assign flush_id    = w_out.flush_id;
  assign flush_exe   = w_out.flush_exe;
  assign hazardState = r_state;

  // State and pending-redirect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_count;

  // Saturating counters of front-end stall cycles and injected EXE bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_out.stall_if  && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_out.flush_exe && (r_bubble_count != 32'hFFFF_FFFF)) r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign stallCycles = r_stall_cycles;
  assign bubbleCount = r_bubble_count;
`endif

endmodule
